clk_ratio_detect: RTL and testbench

- Receive-side companion to the team's clock dividers.
- Samples a divided clock (`div_in`) in the `clk_in` domain, finds its rising edges, and measures two values in `clk_in` cycles:
  - period (rising edge to rising edge);
  - high time.
- Flags lock once the ratio is stable, and flags timeout when edges stop.
- Used in self-checking benches and on-chip monitors to confirm a divider's output ratio and duty.

---
 rtl/clk_ratio_pkg.sv | 15 +
 rtl/clk_ratio_detect_edge_detect.sv | 48 ++++
 rtl/clk_ratio_detect.sv | 157 +++++++++++++++
 tb/tb_clk_ratio_detect.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ratio_pkg.sv
// Shared constants for the divided-clock ratio detector: FSM state encoding
// and default widths.
package clk_ratio_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;
  localparam logic [1:0] ST_LOCKED    = 2'd3;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_CNT = 4;
  // LOCK_CNT is at most 15, so a 4-bit streak counter always suffices.
  localparam int STK_W        = 4;

endpackage

// File: rtl/clk_ratio_detect_edge_detect.sv
// Samples the divided clock and flags its rising edges. Defining
// CLK_RATIO_SYNC_EN adds a 2-flop synchronizer ahead of the sample flop.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_i,
  output logic div_q_o,
  output logic rise_o
);

  logic samp_in;
  logic div_q;
  logic prev_q;

`ifdef CLK_RATIO_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= div_i;
      sync2_q <= sync1_q;
    end
  end

  assign samp_in = sync2_q;
`else
  assign samp_in = div_i;
`endif

  // Reset high so a div_i already high at reset release is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      div_q  <= samp_in;
      prev_q <= div_q;
    end
  end

  assign div_q_o = div_q;
  assign rise_o  = div_q & ~prev_q;

endmodule

// File: rtl/clk_ratio_detect.sv
// Measures period and high time of a divided clock in clk_in cycles, with
// lock and sticky timeout flags. CLK_RATIO_SYNC_EN enables input synchronizer.
module clk_ratio_detect
  import clk_ratio_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);
  localparam logic [STK_W-1:0] STK_LOCK = STK_W'(LOCK_CNT);

  logic             div_q;
  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             same_per;
  logic             cnt_max;
  logic             lock_hit;
  logic [STK_W-1:0] streak_nxt;

  edge_detect u_edge (
    .clk_i   (clk_in),
    .rst_ni  (reset),
    .div_i   (div_in),
    .div_q_o (div_q),
    .rise_o  (rise)
  );

  // streak_q == 0 marks the first measurement after WAIT_EDGE.
  assign same_per   = (streak_q != '0) && (cnt_q == period_q);
  assign streak_nxt = !same_per ? STK_ONE :
                      (streak_q == STK_LOCK) ? streak_q : streak_q + STK_ONE;
  assign lock_hit   = (streak_nxt == STK_LOCK);
  assign cnt_max    = (cnt_q == CNT_MAX);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      streak_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      streak_q  <= streak_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_WAIT_EDGE;
      ST_WAIT_EDGE: if (rise) state_d = ST_MEASURE;
      ST_MEASURE,
      ST_LOCKED: begin
        if (rise)         state_d = lock_hit ? ST_LOCKED : ST_MEASURE;
        else if (cnt_max) state_d = ST_WAIT_EDGE;
      end
      default:      state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // Disable outranks rise, and rise outranks timeout.
  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    streak_d  = streak_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    if (!enable) begin
      cnt_d     = '0;
      hcnt_d    = '0;
      streak_d  = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_EDGE: begin
          if (rise) begin
            cnt_d  = CNT_ONE;
            hcnt_d = CNT_ONE;
          end
        end
        ST_MEASURE,
        ST_LOCKED: begin
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            streak_d  = streak_nxt;
            locked_d  = lock_hit;
            cnt_d     = CNT_ONE;
            hcnt_d    = CNT_ONE;
          end else if (cnt_max) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            streak_d  = '0;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, div_q};
          end
        end
        default: begin
          cnt_d  = '0;
          hcnt_d = '0;
        end
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Bench for clk_ratio_detect: waveform-level reference model feeding an
// expected queue, with a monitor that pops on every valid pulse.
module tb_clk_ratio_detect;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int EXP_W    = 2 * CNT_W + 2;
`ifdef CLK_RATIO_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic             enable = 1'b1;
  logic             div_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;
  logic [1:0]       state_dbg;

  clk_ratio_detect #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .div_in    (div_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int unsigned      due_q[$];
  int               n_cmp = 0;
  int               n_err = 0;

  // Reference model: works on the driven waveform as a list of samples.
  bit   en_m    = 1'b1;
  logic prev_v  = 1'b1;
  bit   in_sess = 1'b0;
  int   cur[$];
  int   pers[$];
  int   last_per = 0;
  bit   exp_lk   = 1'b0;
  bit   exp_to   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit lock_model();
    int n;
    n = pers.size();
    if (n < LOCK_CNT) return 1'b0;
    for (int i = 1; i < LOCK_CNT; i++)
      if (pers[n-1-i] != pers[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic v);
    bit r;
    int per;
    int hi;
    if (!en_m) begin
      prev_v = v;
      return;
    end
    r = v && !prev_v;
    prev_v = v;
    if (r) begin
      if (in_sess) begin
        per = cur.size();
        hi = 0;
        foreach (cur[k]) hi += cur[k];
        pers.push_back(per);
        last_per = per;
        exp_lk = lock_model();
        exp_to = 1'b0;
        exp_q.push_back({CNT_W'(per), CNT_W'(hi), exp_lk, 1'b0});
        due_q.push_back(cyc + LAT);
      end
      in_sess = 1'b1;
      cur.delete();
      cur.push_back(1);
    end else if (in_sess) begin
      if (cur.size() == (1 << CNT_W) - 1) begin
        in_sess = 1'b0;
        exp_to = 1'b1;
        exp_lk = 1'b0;
        cur.delete();
        pers.delete();
      end else begin
        cur.push_back(int'(v));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v);
    @(posedge clk_in);
    #1;
    div_in = v;
    model_step(v);
  endtask

  task automatic pattern(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) drive(1'b1);
      for (int i = 0; i < lo; i++) drive(1'b0);
    end
  endtask

  task automatic set_en(input logic en);
    enable = en;
    en_m = en;
    if (!en) begin
      in_sess = 1'b0;
      cur.delete();
      pers.delete();
      exp_lk = 1'b0;
      exp_to = 1'b0;
    end
  endtask

  task automatic check_flags(input string tag);
    repeat (6) drive(1'b0);
    @(negedge clk_in);
    check({tag, "_valid"}, 32'(valid), 32'(0));
    check({tag, "_locked"}, 32'(locked), 32'(exp_lk));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, "_period"}, 32'(period), 32'(last_per));
  endtask

  task automatic check_reset_outputs();
    check("rst_period", 32'(period), 32'(0));
    check("rst_high_time", 32'(high_time), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
  endtask

  task automatic model_reset();
    in_sess = 1'b0;
    cur.delete();
    pers.delete();
    last_per = 0;
    exp_lk = 1'b0;
    exp_to = 1'b0;
    prev_v = 1'b1;
    check("rst_flush", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    due_q.delete();
  endtask

  // Async reset pulse mid-cycle; release drives v_hold as the first sample.
  task automatic pulse_reset(input logic v_hold);
    @(posedge clk_in);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    div_in = v_hold;
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b1;
    div_in = v_hold;
    model_step(v_hold);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    logic [EXP_W-1:0] e;
    int unsigned      d;
    if (reset && valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d, expected no valid (t=%0t)",
                 period, high_time, $time);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("measurement", 32'({period, high_time, locked, timeout}), 32'(e));
        check("latency", cyc, d);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b1;
    div_in = 1'b0;
    model_step(1'b0);

    pattern(1, 2, 8);            // divide-by-3, locks on 4th valid
    pattern(2, 3, 7);            // divide-by-5, unlock then relock
    pattern(1, 2, 4);
    repeat (300) drive(1'b0);    // edges stop
    check_flags("timeout");
    pattern(1, 2, 5);            // resume: timeout clears with first valid
    check_flags("resume");

    pattern(1, 5, 3);
    repeat (2) drive(1'b0);      // mid-period
    set_en(1'b0);
    check_flags("disable");
    set_en(1'b1);
    repeat (3) drive(1'b0);
    pattern(1, 2, 6);

    pattern(2, 2, 4);
    repeat (3) drive(1'b0);
    pulse_reset(1'b1);           // div_in high across reset release
    repeat (3) drive(1'b1);
    pattern(1, 2, 6);

    for (int seg = 0; seg < 14; seg++) begin
      case ($urandom_range(0, 4))
        0: begin
          repeat (5) drive(1'b0);
          set_en(1'b0);
          repeat (3) drive(1'b0);
          set_en(1'b1);
          repeat (4) drive(1'b0);
        end
        1: begin
          for (int i = 0; i < 30; i++) drive(1'($urandom_range(0, 1)));
        end
        default: pattern($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(2, 8));
      endcase
    end

    repeat (8) drive(1'b0);
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
